// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcodes, FSM states and the iteration
// counter sizing helper.
package alu_pkg;

    typedef enum logic [2:0] {
        ALU_ADD   = 3'b000,
        ALU_AND   = 3'b001,
        ALU_NOT   = 3'b010,
        ALU_PASS  = 3'b011,
        ALU_MUL   = 3'b100,
        ALU_DIV   = 3'b101,
        ALU_RSVD6 = 3'b110,
        ALU_RSVD7 = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } alu_state_e;

    // Bits needed to count iterations 0..w-1.
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/seq_muldiv_core.sv
// Iterative unsigned shift-add multiplier / restoring divider, one bit per
// clock, sharing a single WIDTH+1-bit adder/subtractor.
module seq_muldiv_core
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             is_div_i,
    input  logic             step_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             last_o,
    output logic [WIDTH-1:0] res_lo_o,
    output logic [WIDTH-1:0] res_hi_o
);

    localparam int unsigned CntW = cnt_width(WIDTH);

    // hi: product upper half / partial remainder; lo: multiplier / dividend-quotient.
    logic [WIDTH:0]   hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] opnd_q;
    logic             div_q;
    logic [CntW-1:0]  cnt_q;

    logic [WIDTH:0]   add_a, add_b;
    logic             add_cin;
    logic [WIDTH+1:0] add_full;
    logic             carry;

    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        if (div_q) begin
            add_a   = {hi_q[WIDTH-1:0], lo_q[WIDTH-1]};
            add_b   = ~{1'b0, opnd_q};
            add_cin = 1'b1;
        end else begin
            add_a = {1'b0, hi_q[WIDTH-1:0]};
            add_b = lo_q[0] ? {1'b0, opnd_q} : '0;
        end
    end

    assign add_full = {1'b0, add_a} + {1'b0, add_b} + {{(WIDTH + 1){1'b0}}, add_cin};
    // For subtraction, carry out set means no borrow: the trial result is non-negative.
    assign carry = add_full[WIDTH+1];

    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (div_q) begin
            hi_d = carry ? add_full[WIDTH:0] : add_a;
            lo_d = {lo_q[WIDTH-2:0], carry};
        end else begin
            hi_d = {1'b0, add_full[WIDTH:1]};
            lo_d = {add_full[0], lo_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hi_q   <= '0;
            lo_q   <= '0;
            opnd_q <= '0;
            div_q  <= 1'b0;
            cnt_q  <= '0;
        end else if (load_i) begin
            hi_q   <= '0;
            lo_q   <= is_div_i ? a_i : b_i;
            opnd_q <= is_div_i ? b_i : a_i;
            div_q  <= is_div_i;
            cnt_q  <= '0;
        end else if (step_i) begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign last_o   = (cnt_q == CntW'(WIDTH - 1));
    // Results after the current iteration, captured by the top on the final edge.
    assign res_lo_o = lo_d;
    assign res_hi_o = hi_d[WIDTH-1:0];

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle add/and/not/pass, iterative mul/div behind a
// start/done handshake.
module seq_alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             start,
    input  logic [2:0]       select,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] data_out,
    output logic [WIDTH-1:0] aux_reg,
    output logic             div_by_zero
);

    alu_state_e       state_q, state_d;
    alu_op_e          op_q, op_d, op_in;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] aux_q, aux_d;
    logic             dbz_q, dbz_d;

    logic             core_load, core_div, core_last;
    logic [WIDTH-1:0] core_lo, core_hi;

    assign op_in = alu_op_e'(select);

    seq_muldiv_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk_i   (Clk),
        .rst_i   (Reset),
        .load_i  (core_load),
        .is_div_i(core_div),
        .step_i  (state_q == S_RUN),
        .a_i     (A),
        .b_i     (B),
        .last_o  (core_last),
        .res_lo_o(core_lo),
        .res_hi_o(core_hi)
    );

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        data_d    = data_q;
        aux_d     = aux_q;
        dbz_d     = dbz_q;
        core_load = 1'b0;
        core_div  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d    = op_in;
                    dbz_d   = 1'b0;
                    state_d = S_DONE;
                    case (op_in)
                        ALU_ADD: begin
                            data_d = A + B;
                            aux_d  = '0;
                        end
                        ALU_AND: begin
                            data_d = A & B;
                            aux_d  = '0;
                        end
                        ALU_NOT: begin
                            data_d = ~A;
                            aux_d  = '0;
                        end
                        ALU_PASS: begin
                            data_d = A;
                            aux_d  = '0;
                        end
                        ALU_MUL: begin
                            core_load = 1'b1;
                            state_d   = S_RUN;
                        end
                        ALU_DIV: begin
                            if (B == '0) begin
                                data_d = '1;
                                aux_d  = A;
                                dbz_d  = 1'b1;
                            end else begin
                                core_load = 1'b1;
                                core_div  = 1'b1;
                                state_d   = S_RUN;
                            end
                        end
                        default: begin
                            data_d = '0;
                            aux_d  = '0;
                        end
                    endcase
                end
            end
            S_RUN: begin
                if (core_last) begin
                    data_d  = core_lo;
                    aux_d   = core_hi;
                    state_d = S_DONE;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
            op_q    <= ALU_ADD;
            data_q  <= '0;
            aux_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            data_q  <= data_d;
            aux_q   <= aux_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign data_out    = data_q;
    assign aux_reg     = aux_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed, table-driven bench for seq_alu at WIDTH=16, plus handshake and
// mid-operation reset sequences.
module tb_seq_alu;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        start;
    logic [2:0]  select;
    logic [15:0] A, B;
    logic        busy, done, div_by_zero;
    logic [15:0] data_out, aux_reg;

    int checks = 0;
    int errors = 0;

    seq_alu #(
        .WIDTH(16)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .start      (start),
        .select     (select),
        .A          (A),
        .B          (B),
        .busy       (busy),
        .done       (done),
        .data_out   (data_out),
        .aux_reg    (aux_reg),
        .div_by_zero(div_by_zero)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [2:0]  sel;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp_data;
        logic [15:0] exp_aux;
        logic        exp_dbz;
        int          exp_lat;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Latency counts edges from E0 up to and including the edge that raises done.
    task automatic run_op(input string tag, input logic [2:0] sel, input logic [15:0] a,
                          input logic [15:0] b, input logic [15:0] exp_d,
                          input logic [15:0] exp_a, input logic exp_z, input int exp_lat);
        int lat;
        @(negedge Clk);
        select = sel;
        A      = a;
        B      = b;
        start  = 1'b1;
        @(posedge Clk);
        #1;
        start  = 1'b0;
        A      = ~a;
        B      = ~b;
        select = ~sel;
        check({tag, " busy"}, 32'(busy), 32'd1);
        lat = 1;
        while (!done && lat < 40) begin
            @(posedge Clk);
            #1;
            lat++;
        end
        check({tag, " done"}, 32'(done), 32'd1);
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " data_out"}, 32'(data_out), 32'(exp_d));
        check({tag, " aux_reg"}, 32'(aux_reg), 32'(exp_a));
        check({tag, " div_by_zero"}, 32'(div_by_zero), 32'(exp_z));
        @(posedge Clk);
        #1;
        check({tag, " idle after done"}, {30'd0, done, busy}, 32'd0);
        check({tag, " data held"}, 32'(data_out), 32'(exp_d));
    endtask

    initial begin
        int          done_cnt;
        logic [15:0] cap_d, cap_a;

        vecs[0]  = '{3'b000, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 1'b0, 1};
        vecs[1]  = '{3'b001, 16'hF0F0, 16'h3C3C, 16'h3030, 16'h0000, 1'b0, 1};
        vecs[2]  = '{3'b010, 16'h1234, 16'h0000, 16'hEDCB, 16'h0000, 1'b0, 1};
        vecs[3]  = '{3'b011, 16'hBEEF, 16'h1111, 16'hBEEF, 16'h0000, 1'b0, 1};
        vecs[4]  = '{3'b100, 16'h1234, 16'h5678, 16'h0060, 16'h0626, 1'b0, 17};
        vecs[5]  = '{3'b100, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 1'b0, 17};
        vecs[6]  = '{3'b101, 16'd100,  16'd7,    16'h000E, 16'h0002, 1'b0, 17};
        vecs[7]  = '{3'b101, 16'd5,    16'd9,    16'h0000, 16'h0005, 1'b0, 17};
        vecs[8]  = '{3'b101, 16'h0042, 16'h0000, 16'hFFFF, 16'h0042, 1'b1, 1};
        vecs[9]  = '{3'b000, 16'h0003, 16'h0004, 16'h0007, 16'h0000, 1'b0, 1};
        vecs[10] = '{3'b110, 16'h1234, 16'h5678, 16'h0000, 16'h0000, 1'b0, 1};
        vecs[11] = '{3'b100, 16'h0000, 16'hABCD, 16'h0000, 16'h0000, 1'b0, 17};
        vecs[12] = '{3'b101, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 17};
        vecs[13] = '{3'b111, 16'hAAAA, 16'h5555, 16'h0000, 16'h0000, 1'b0, 1};
        vecs[14] = '{3'b000, 16'h8000, 16'h8001, 16'h0001, 16'h0000, 1'b0, 1};

        Reset  = 1'b0;
        start  = 1'b0;
        select = 3'b000;
        A      = 16'h0;
        B      = 16'h0;
        #2 Reset = 1'b1;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        check("reset outputs", {13'd0, busy, done, div_by_zero, data_out}, 32'd0);
        check("reset aux_reg", 32'(aux_reg), 32'd0);
        Reset = 1'b0;

        for (int i = 0; i < 15; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].sel, vecs[i].a, vecs[i].b,
                   vecs[i].exp_data, vecs[i].exp_aux, vecs[i].exp_dbz, vecs[i].exp_lat);
        end

        // start held through the whole RUN/DONE window with operands changing.
        @(negedge Clk);
        select = 3'b100;
        A      = 16'd3;
        B      = 16'd5;
        start  = 1'b1;
        done_cnt = 0;
        cap_d    = 16'hDEAD;
        cap_a    = 16'hDEAD;
        for (int c = 0; c < 30; c++) begin
            @(posedge Clk);
            #1;
            if (c == 17) begin
                start = 1'b0;
            end else if (c < 17) begin
                A = 16'(c * 7 + 1);
                B = 16'(c * 3 + 2);
            end
            if (done) begin
                done_cnt++;
                cap_d = data_out;
                cap_a = aux_reg;
            end
        end
        check("hold start done count", 32'(done_cnt), 32'd1);
        check("hold start product lo", 32'(cap_d), 32'd15);
        check("hold start product hi", 32'(cap_a), 32'd0);
        check("hold start idle", 32'(busy), 32'd0);

        // Reset during iteration 8 of a multiply.
        @(negedge Clk);
        select = 3'b100;
        A      = 16'h1234;
        B      = 16'h5678;
        start  = 1'b1;
        @(posedge Clk);
        #1;
        start = 1'b0;
        repeat (8) @(posedge Clk);
        #2 Reset = 1'b1;
        #1;
        check("mid-run reset data_out", 32'(data_out), 32'd0);
        check("mid-run reset flags", {29'd0, busy, done, div_by_zero}, 32'd0);
        check("mid-run reset aux_reg", 32'(aux_reg), 32'd0);
        @(negedge Clk);
        Reset = 1'b0;
        done_cnt = 0;
        for (int c = 0; c < 25; c++) begin
            @(posedge Clk);
            #1;
            if (done) done_cnt++;
        end
        check("no done after reset", 32'(done_cnt), 32'd0);
        check("idle after reset", 32'(busy), 32'd0);
        run_op("div after reset", 3'b101, 16'd100, 16'd7, 16'h000E, 16'h0002, 1'b0, 17);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
